// File: rtl/reg_bank_wr8x16_pkg.sv
// Shared definitions for the 8x16 write-side register bank.
//   state_t   : clear sequencer state encoding
//   NREG      : number of registers in the bank
//   SEL_W     : width of a register index
//   DEF_WIDTH : default register data width
package reg_bank_wr8x16_pkg;

  localparam int NREG      = 8;
  localparam int SEL_W     = 3;
  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CLEAR = 2'b01,
    FIN   = 2'b10
  } state_t;

endpackage

// File: rtl/reg_bank_wr8x16_dec.sv
// dec3_8_en: 3-to-8 one-hot decoder with a common enable.
//   en     : when low, every output is low
//   sel    : register index to decode
//   onehot : one-hot select, bit sel set when en is high
module dec3_8_en
  import reg_bank_wr8x16_pkg::*;
(
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [NREG-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NREG; i++) begin
      if (en && (sel == SEL_W'(i))) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_bank_wr8x16.sv
// reg_bank_wr8x16: eight WIDTH-bit registers written through a 1:8 demux,
// with a sequenced clear (one register per cycle) and write bookkeeping.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | writes accepted; CLR starts the clear sequence
//   CLEAR | R[idx] cleared each cycle; writes dropped (WERR); BUSY high
//   FIN   | one-cycle DONE pulse; writes accepted, CLR ignored
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   we    : write request
//   wsel  : write target index
//   wdata : write data
//   clr   : start clear sequence (honoured in IDLE only)
//   q     : flat register bus, R[i] = q[WIDTH*i +: WIDTH]
//   wack  : pulse, previous cycle's write was accepted
//   werr  : pulse, previous cycle's write was dropped while busy
//   busy  : clear sequence running
//   done  : pulse, clear sequence finished
//   wrcnt : accepted write count, wraps silently
module reg_bank_wr8x16
  import reg_bank_wr8x16_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter bit R0_ZERO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [SEL_W-1:0]      wsel,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  clr,
  output logic [NREG*WIDTH-1:0] q,
  output logic                  wack,
  output logic                  werr,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           wrcnt
);

  state_t           state;
  logic [SEL_W-1:0] idx;
  logic             wr_accept;
  logic             in_clear;
  logic [NREG-1:0]  wen;
  logic [NREG-1:0]  clr_hit;

  assign in_clear  = (state == CLEAR);
  assign wr_accept = we && !in_clear;

  dec3_8_en u_wr_dec (
    .en     (wr_accept),
    .sel    (wsel),
    .onehot (wen)
  );

  // Same decoder picks the register being cleared this cycle.
  dec3_8_en u_clr_dec (
    .en     (in_clear),
    .sel    (idx),
    .onehot (clr_hit)
  );

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    logic [WIDTH-1:0] r;

    // A hardwired-zero R0 still takes the write strobe but only ever loads 0,
    // so it stays at its reset value and the accept/count path is unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r <= '0;
      end else if (clr_hit[i]) begin
        r <= '0;
      end else if (wen[i]) begin
        r <= (i == 0 && R0_ZERO) ? '0 : wdata;
      end
    end

    assign q[WIDTH*i +: WIDTH] = r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      wack  <= 1'b0;
      werr  <= 1'b0;
      wrcnt <= '0;
    end else begin
      wack <= wr_accept;
      werr <= we && in_clear;
      done <= 1'b0;
      if (wr_accept) begin
        wrcnt <= wrcnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          idx <= idx + SEL_W'(1);
          if (idx == SEL_W'(NREG - 1)) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_wr8x16.sv
module tb_reg_bank_wr8x16;

  logic         clk;
  logic         rst_n;
  logic         we;
  logic [2:0]   wsel;
  logic [15:0]  wdata;
  logic         clr;

  logic [127:0] q0,     q1;
  logic         wack0,  wack1;
  logic         werr0,  werr1;
  logic         busy0,  busy1;
  logic         done0,  done1;
  logic [15:0]  wrcnt0, wrcnt1;

  int checks = 0;
  int errors = 0;

  reg_bank_wr8x16 #(.WIDTH(16), .R0_ZERO(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wsel(wsel), .wdata(wdata), .clr(clr),
    .q(q0), .wack(wack0), .werr(werr0), .busy(busy0), .done(done0), .wrcnt(wrcnt0)
  );

  reg_bank_wr8x16 #(.WIDTH(16), .R0_ZERO(1'b1)) u_dut_r0z (
    .clk(clk), .rst_n(rst_n), .we(we), .wsel(wsel), .wdata(wdata), .clr(clr),
    .q(q1), .wack(wack1), .werr(werr1), .busy(busy1), .done(done1), .wrcnt(wrcnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sl(input logic [127:0] qv, input int i);
    return qv[i*16 +: 16];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    we    = 1'b0;
    clr   = 1'b0;
    wsel  = '0;
    wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Runs until the DUT has been idle after DONE, counting busy and done cycles.
  task automatic run_clear(output int busy_cyc, output int done_cnt);
    busy_cyc = 0;
    done_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      if (busy0) busy_cyc++;
      if (done0) done_cnt++;
      tick();
    end
  endtask

  initial begin
    int bc, dc;
    logic all_zero;

    // Reset state and sequential writes R[i] = i
    do_reset();
    #1;
    check_val("rst_q",     32'(q0 == '0), 32'd1);
    check_val("rst_busy",  32'(busy0), 32'd0);
    check_val("rst_done",  32'(done0), 32'd0);
    check_val("rst_wack",  32'(wack0), 32'd0);
    check_val("rst_werr",  32'(werr0), 32'd0);
    check_val("rst_wrcnt", 32'(wrcnt0), 32'd0);
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wsel = 3'(i); wdata = 16'(i);
      tick();
      check_val($sformatf("wr_q%0d", i), 32'(sl(q0, i)), 32'(i));
      check_val($sformatf("wr_wack%0d", i), 32'(wack0), 32'd1);
    end
    we = 1'b0;
    tick();
    check_val("wr_wack_off", 32'(wack0), 32'd0);
    check_val("wr_wrcnt8",   32'(wrcnt0), 32'd8);
    check_val("wr_q_r7",     32'(sl(q0, 7)), 32'd7);
    check_val("r0z_q0",      32'(sl(q1, 0)), 32'd0);
    check_val("r0z_wrcnt8",  32'(wrcnt1), 32'd8);

    // Write R3 then clear
    do_reset();
    we = 1'b1; wsel = 3'd3; wdata = 16'hBEEF;
    tick();
    we = 1'b0;
    check_val("clr_q3_pre", 32'(sl(q0, 3)), 32'h0000BEEF);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    run_clear(bc, dc);
    check_val("clr_busy_cyc", 32'(bc), 32'd8);
    check_val("clr_done_cnt", 32'(dc), 32'd1);
    check_val("clr_q_zero",   32'(q0 == '0), 32'd1);
    check_val("clr_wrcnt",    32'(wrcnt0), 32'd1);
    check_val("clr_busy_end", 32'(busy0), 32'd0);

    // Write attempt during CLEAR (CLR also held to confirm no restart)
    do_reset();
    we = 1'b1; wsel = 3'd5; wdata = 16'h5555;
    tick();
    we = 1'b0; clr = 1'b1;
    tick();
    tick();
    we = 1'b1; wsel = 3'd5; wdata = 16'h1234;
    tick();
    we = 1'b0;
    check_val("ce_werr",  32'(werr0), 32'd1);
    check_val("ce_wack",  32'(wack0), 32'd0);
    check_val("ce_q5",    32'(sl(q0, 5)), 32'h00005555);
    check_val("ce_wrcnt", 32'(wrcnt0), 32'd1);
    tick();
    check_val("ce_werr_off", 32'(werr0), 32'd0);
    clr = 1'b0;
    run_clear(bc, dc);
    check_val("ce_busy_rem", 32'(bc), 32'd5);
    check_val("ce_done",     32'(dc), 32'd1);
    check_val("ce_q5_after", 32'(sl(q0, 5)), 32'd0);
    check_val("ce_wrcnt_after", 32'(wrcnt0), 32'd1);

    // Simultaneous write and clear
    do_reset();
    we = 1'b1; wsel = 3'd7; wdata = 16'hAAAA; clr = 1'b1;
    tick();
    we = 1'b0; clr = 1'b0;
    check_val("wc_wack",  32'(wack0), 32'd1);
    check_val("wc_wrcnt", 32'(wrcnt0), 32'd1);
    check_val("wc_q7",    32'(sl(q0, 7)), 32'h0000AAAA);
    check_val("wc_busy",  32'(busy0), 32'd1);
    run_clear(bc, dc);
    check_val("wc_done",     32'(dc), 32'd1);
    check_val("wc_q7_after", 32'(sl(q0, 7)), 32'd0);

    // Hardwired R0
    do_reset();
    we = 1'b1; wsel = 3'd0; wdata = 16'hFFFF;
    tick();
    we = 1'b0;
    check_val("r0z_wack",   32'(wack1), 32'd1);
    check_val("r0z_wrcnt",  32'(wrcnt1), 32'd1);
    check_val("r0z_r0",     32'(sl(q1, 0)), 32'd0);
    check_val("r0n_r0",     32'(sl(q0, 0)), 32'h0000FFFF);

    // Reset in the middle of a clear
    do_reset();
    we = 1'b1; wsel = 3'd7; wdata = 16'h7777;
    tick();
    we = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    tick();
    check_val("mr_busy_pre", 32'(busy0), 32'd1);
    check_val("mr_q7_pre",   32'(sl(q0, 7)), 32'h00007777);
    rst_n = 1'b0;
    #1;
    check_val("mr_q_zero", 32'(q0 == '0), 32'd1);
    check_val("mr_busy",   32'(busy0), 32'd0);
    check_val("mr_done",   32'(done0), 32'd0);
    dc = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (done0) dc++;
    end
    rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (done0) dc++;
    end
    check_val("mr_no_done", 32'(dc), 32'd0);
    all_zero = (q0 == '0) && !busy0;
    check_val("mr_idle_zero", 32'(all_zero), 32'd1);

    // Counter wrap
    we = 1'b1; wsel = 3'd1; wdata = 16'h0101;
    for (int n = 0; n < 65535; n++) begin
      tick();
    end
    check_val("wrap_ffff", 32'(wrcnt0), 32'h0000FFFF);
    tick();
    we = 1'b0;
    check_val("wrap_zero",     32'(wrcnt0), 32'd0);
    check_val("wrap_zero_r0z", 32'(wrcnt1), 32'd0);
    check_val("wrap_q1",       32'(sl(q0, 1)), 32'h00000101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
